// File: rtl/ibniz_video_timing_if.sv
// Pixel-coordinate / colour-return / display bundle between the Ibniz timing
// generator (master) and the adapter plus display sink (slave).
interface ibniz_video_timing_if;
  logic signed [11:0] oX_video;
  logic signed [11:0] oY_video;
  logic               endFrame;
  logic        [7:0]  iR_video;
  logic        [7:0]  iG_video;
  logic        [7:0]  iB_video;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_de;
  logic        [7:0]  vga_r;
  logic        [7:0]  vga_g;
  logic        [7:0]  vga_b;

  modport master (
    output oX_video, oY_video, endFrame,
    input  iR_video, iG_video, iB_video,
    output vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
  );

  modport slave (
    input  oX_video, oY_video, endFrame,
    output iR_video, iG_video, iB_video,
    input  vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/ibniz_video_timing.sv
// Raster timing generator for the Ibniz demo path: emits pixel coordinates,
// takes back the adapter's colour PIPE_LAT clocks later and drives the display.
module ibniz_video_timing #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ibniz_video_timing_if.master  vid
);

  localparam int unsigned CW      = 12;
  localparam int unsigned PW      = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON  = HS_POL;
  localparam logic HS_OFF = ~HS_POL;
  localparam logic VS_ON  = VS_POL;
  localparam logic VS_OFF = ~VS_POL;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          w_h_wrap;
  logic          w_v_wrap;

  logic          w_de_raw;
  logic          w_hs_raw;
  logic          w_vs_raw;

  logic [PIPE_LAT-1:0] r_de_pipe;
  logic [PIPE_LAT-1:0] r_hs_pipe;
  logic [PIPE_LAT-1:0] r_vs_pipe;

  logic          w_de_d;
  logic          w_hs_d;
  logic          w_vs_d;

  logic          w_vga_de_nxt;
  logic          w_vga_hs_nxt;
  logic          w_vga_vs_nxt;
  logic [PW-1:0] w_vga_r_nxt;
  logic [PW-1:0] w_vga_g_nxt;
  logic [PW-1:0] w_vga_b_nxt;

  logic          r_vga_de;
  logic          r_vga_hs;
  logic          r_vga_vs;
  logic [PW-1:0] r_vga_r;
  logic [PW-1:0] r_vga_g;
  logic [PW-1:0] r_vga_b;

  // Line and frame wrap share one edge so (H_LAST,V_LAST) is followed by (0,0).
  always_comb begin
    w_h_wrap = 1'b0;
    w_v_wrap = 1'b0;
    if (r_h_cnt == H_LAST) w_h_wrap = 1'b1;
    if (r_v_cnt == V_LAST) w_v_wrap = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        if (w_v_wrap) r_v_cnt <= '0;
        else          r_v_cnt <= r_v_cnt + CW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CW'(1);
      end
    end
  end

  // Undelayed window/sync decode of the current coordinate.
  always_comb begin
    w_de_raw = 1'b0;
    w_hs_raw = 1'b0;
    w_vs_raw = 1'b0;
    if ((r_h_cnt < H_ACT) && (r_v_cnt < V_ACT))         w_de_raw = 1'b1;
    if ((r_h_cnt >= HS_START) && (r_h_cnt < HS_END))    w_hs_raw = 1'b1;
    if ((r_v_cnt >= VS_START) && (r_v_cnt < VS_END))    w_vs_raw = 1'b1;
  end

  // Control delay line; the top bit lines up with the adapter's returning colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_de_pipe <= '0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
    end else begin
      r_de_pipe <= PIPE_LAT'({r_de_pipe, w_de_raw});
      r_hs_pipe <= PIPE_LAT'({r_hs_pipe, w_hs_raw});
      r_vs_pipe <= PIPE_LAT'({r_vs_pipe, w_vs_raw});
    end
  end

  assign w_de_d = r_de_pipe[PIPE_LAT-1];
  assign w_hs_d = r_hs_pipe[PIPE_LAT-1];
  assign w_vs_d = r_vs_pipe[PIPE_LAT-1];

  // Colour is blanked outside the active window whatever the adapter returns.
  always_comb begin
    w_vga_de_nxt = w_de_d;
    w_vga_hs_nxt = HS_OFF;
    w_vga_vs_nxt = VS_OFF;
    w_vga_r_nxt  = '0;
    w_vga_g_nxt  = '0;
    w_vga_b_nxt  = '0;
    if (w_hs_d) w_vga_hs_nxt = HS_ON;
    if (w_vs_d) w_vga_vs_nxt = VS_ON;
    if (w_de_d) begin
      w_vga_r_nxt = vid.iR_video;
      w_vga_g_nxt = vid.iG_video;
      w_vga_b_nxt = vid.iB_video;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vga_de <= 1'b0;
      r_vga_hs <= HS_OFF;
      r_vga_vs <= VS_OFF;
      r_vga_r  <= '0;
      r_vga_g  <= '0;
      r_vga_b  <= '0;
    end else begin
      r_vga_de <= w_vga_de_nxt;
      r_vga_hs <= w_vga_hs_nxt;
      r_vga_vs <= w_vga_vs_nxt;
      r_vga_r  <= w_vga_r_nxt;
      r_vga_g  <= w_vga_g_nxt;
      r_vga_b  <= w_vga_b_nxt;
    end
  end

  // endFrame is a decode of the counter registers, not a separate flop.
  assign vid.oX_video = $signed(r_h_cnt);
  assign vid.oY_video = $signed(r_v_cnt);
  assign vid.endFrame = w_h_wrap & w_v_wrap;

  assign vid.vga_de = r_vga_de;
  assign vid.vga_hs = r_vga_hs;
  assign vid.vga_vs = r_vga_vs;
  assign vid.vga_r  = r_vga_r;
  assign vid.vga_g  = r_vga_g;
  assign vid.vga_b  = r_vga_b;

endmodule
